// File: rtl/uart_tx_reporter.sv
// uart_tx_reporter: byte FIFO feeding an 8N1 UART serialiser for the host link
module uart_tx_reporter #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_AW      = 4
) (
  input  logic               CLK_50,
  input  logic               nRst,
  input  logic               iWR_EN,
  input  logic [7:0]         iWR_DATA,
  input  logic               iCLR_OVF,
  output logic               oTXD,
  output logic               oFULL,
  output logic               oEMPTY,
  output logic [FIFO_AW:0]   oLEVEL,
  output logic               oBUSY,
  output logic               oOVERFLOW
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic pop, wr_ok, bit_end;
  logic [FIFO_AW:0] level_n;

  // oFULL is the registered pre-pop view, so a write while full is dropped even if a pop coincides
  assign wr_ok = iWR_EN & ~oFULL;
  assign bit_end = cnt == LAST;
  assign level_n = oLEVEL + (FIFO_AW+1)'(wr_ok) - (FIFO_AW+1)'(pop);

  // FIFO storage; contents need no reset because occupancy is tracked by the pointers
  always_ff @(posedge CLK_50)
    if (wr_ok) mem[wr_ptr] <= iWR_DATA;

  // FIFO pointers, occupancy flags and sticky overflow (set beats clear)
  always_ff @(posedge CLK_50 or negedge nRst)
    if (!nRst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      oLEVEL    <= '0;
      oFULL     <= 1'b0;
      oEMPTY    <= 1'b1;
      oOVERFLOW <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      oLEVEL    <= level_n;
      oFULL     <= level_n == (FIFO_AW+1)'(DEPTH);
      oEMPTY    <= level_n == '0;
      oOVERFLOW <= (iWR_EN & oFULL) | (oOVERFLOW & ~iCLR_OVF);
    end

  // serialiser state and registered line outputs, which follow the next state
  always_ff @(posedge CLK_50 or negedge nRst)
    if (!nRst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      oTXD  <= 1'b1;
      oBUSY <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      oTXD  <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
      oBUSY <= state_n != IDLE;
    end

  // next-state: stop bit's last cycle may pop straight into a new start bit
  always_comb begin
    state_n = state;
    cnt_n   = state == IDLE ? '0 : bit_end ? '0 : cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE:
        if (!oEMPTY) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      START:
        if (bit_end) begin
          idx_n   = '0;
          state_n = DATA;
        end
      DATA:
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 1'b1;
          state_n = idx == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (bit_end) begin
          pop     = !oEMPTY;
          shift_n = oEMPTY ? shift : mem[rd_ptr];
          state_n = oEMPTY ? IDLE : START;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule
